// File: rtl/rd_bus_pkg.sv
// Shared definitions for both ends of the go/rd/ws/ds read-strobe interface.
package rd_bus_pkg;

  // Target (responder) state encodings
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_REQ  = 2'b01;
  localparam logic [1:0] T_HOLD = 2'b10;

  // Initiator state encodings
  localparam logic [1:0] I_IDLE = 2'b00;
  localparam logic [1:0] I_READ = 2'b01;
  localparam logic [1:0] I_DLY  = 2'b10;
  localparam logic [1:0] I_DONE = 2'b11;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rd_wait_ctr.sv
// Saturating wait counter for the target's request phase; flags are registered
// so they line up with the count they describe.
module rd_wait_ctr #(
  parameter int unsigned MIN_WAIT = 1,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CW       = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic ge_min,
  output logic at_timeout
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (load) begin
      cnt_d = CW'(1);
    end else if (en && (cnt != CW'(TIMEOUT))) begin
      cnt_d = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      ge_min     <= 1'b0;
      at_timeout <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      ge_min     <= (cnt_d >= CW'(MIN_WAIT));
      at_timeout <= (cnt_d == CW'(TIMEOUT));
    end
  end

endmodule

// File: rtl/rd_target.sv
// Responder end of the rd/ws/ds read interface: holds ws while fetching a word
// over a req/ack memory handshake, then presents rdata until the initiator's ds.
module rd_target
  import rd_bus_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 8,
  parameter int          MIN_WAIT = 1,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd,
  input  logic          ds,
  input  logic [AW-1:0] addr,
  output logic          ws,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned MIN_EFF = (MIN_WAIT < 1) ? 32'd1 : 32'(MIN_WAIT);
  localparam int unsigned CW      = $clog2(TIMEOUT + 1);

  logic [1:0]    state, state_d;
  logic          have_data, have_d;
  logic          ws_d, err_d, mem_req_d;
  logic [DW-1:0] rdata_d;
  logic [AW-1:0] mem_addr_d;
  logic          cnt_load, cnt_en;
  logic          ge_min, at_timeout;
  logic          ack_ok, got_data;

  // A stray ack is only meaningful while a request is outstanding
  assign ack_ok   = mem_ack & mem_req;
  assign got_data = have_data | ack_ok;
  assign cnt_en   = (state == T_REQ);

  rd_wait_ctr #(
    .MIN_WAIT(MIN_EFF),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .en        (cnt_en),
    .ge_min    (ge_min),
    .at_timeout(at_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= T_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    ws_d       = ws;
    err_d      = err;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    rdata_d    = rdata;
    have_d     = have_data;
    cnt_load   = 1'b0;
    case (state)
      T_IDLE: begin
        ws_d      = 1'b0;
        mem_req_d = 1'b0;
        if (rd) begin
          state_d    = T_REQ;
          mem_addr_d = addr;
          cnt_load   = 1'b1;
          have_d     = 1'b0;
          err_d      = 1'b0;
          ws_d       = 1'b1;
          mem_req_d  = 1'b1;
        end
      end
      T_REQ: begin
        if (!rd) begin
          state_d   = T_IDLE;
          ws_d      = 1'b0;
          mem_req_d = 1'b0;
        end else begin
          if (ack_ok) begin
            rdata_d   = mem_rdata;
            have_d    = 1'b1;
            mem_req_d = 1'b0;
          end
          // Data arriving on the timeout cycle takes precedence over the error
          if (got_data && ge_min) begin
            state_d   = T_HOLD;
            ws_d      = 1'b0;
            mem_req_d = 1'b0;
          end else if (!got_data && at_timeout) begin
            state_d   = T_HOLD;
            ws_d      = 1'b0;
            mem_req_d = 1'b0;
            rdata_d   = ERR_DATA;
            err_d     = 1'b1;
          end
        end
      end
      T_HOLD: begin
        ws_d      = 1'b0;
        mem_req_d = 1'b0;
        if (ds || !rd) begin
          state_d = T_IDLE;
        end
      end
      default: begin
        state_d   = T_IDLE;
        ws_d      = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws        <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      rdata     <= '0;
      have_data <= 1'b0;
    end else begin
      ws        <= ws_d;
      err       <= err_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      rdata     <= rdata_d;
      have_data <= have_d;
    end
  end

endmodule

// File: tb/tb_rd_target.sv
// Directed bench for rd_target: three instances (default, MIN_WAIT=4, TIMEOUT=8)
// share stimulus; each vector names the instance whose outputs it checks.
module tb_rd_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rd, ds, mem_ack;
  logic [7:0]  addr;
  logic [31:0] mem_rdata;

  logic [2:0]  ws_w, err_w, mr_w;
  logic [31:0] rdata_w [3];
  logic [7:0]  ma_w [3];

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  rd_target u0 (
    .clk(clk), .reset(reset), .rd(rd), .ds(ds), .addr(addr),
    .ws(ws_w[0]), .rdata(rdata_w[0]), .err(err_w[0]),
    .mem_req(mr_w[0]), .mem_addr(ma_w[0]), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  rd_target #(.MIN_WAIT(4)) u1 (
    .clk(clk), .reset(reset), .rd(rd), .ds(ds), .addr(addr),
    .ws(ws_w[1]), .rdata(rdata_w[1]), .err(err_w[1]),
    .mem_req(mr_w[1]), .mem_addr(ma_w[1]), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  rd_target #(.TIMEOUT(8)) u2 (
    .clk(clk), .reset(reset), .rd(rd), .ds(ds), .addr(addr),
    .ws(ws_w[2]), .rdata(rdata_w[2]), .err(err_w[2]),
    .mem_req(mr_w[2]), .mem_addr(ma_w[2]), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          dut;
    logic        rst, rd, ds, ack;
    logic [7:0]  addr;
    logic [31:0] md;
    logic        ews, emr, eerr;
    logic [7:0]  ema;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int d, logic rs, logic r, logic s, logic a,
                              logic [7:0] ad, logic [31:0] md,
                              logic w, logic m, logic e,
                              logic [7:0] ma, logic [31:0] rdv);
    vec_t v;
    v.dut = d; v.rst = rs; v.rd = r; v.ds = s; v.ack = a;
    v.addr = ad; v.md = md; v.ews = w; v.emr = m; v.eerr = e;
    v.ema = ma; v.erd = rdv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_dut(input string tag, input int d, input logic w, input logic m,
                         input logic e, input logic [7:0] ma, input logic [31:0] rdv);
    chk({tag, ".ws"},       32'(ws_w[d]),  32'(w));
    chk({tag, ".mem_req"},  32'(mr_w[d]),  32'(m));
    chk({tag, ".err"},      32'(err_w[d]), 32'(e));
    chk({tag, ".mem_addr"}, 32'(ma_w[d]),  32'(ma));
    chk({tag, ".rdata"},    rdata_w[d],    rdv);
  endtask

  task automatic drive(input logic rs, input logic r, input logic s, input logic a,
                       input logic [7:0] ad, input logic [31:0] md);
    reset = rs; rd = r; ds = s; mem_ack = a; addr = ad; mem_rdata = md;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step;
    step;
    for (int d = 0; d < 3; d++) chk_dut($sformatf("reset_u%0d", d), d, 0, 0, 0, 8'h00, 32'h0);

    // Basic read on default instance
    tbl.push_back(mk(0, 1,0,0,0, 8'h00, 32'h0,          0,0,0, 8'h00, 32'h0));
    tbl.push_back(mk(0, 0,1,0,0, 8'h10, 32'h0,          1,1,0, 8'h10, 32'h0));
    tbl.push_back(mk(0, 0,1,0,1, 8'h10, 32'h1234_5678,  0,0,0, 8'h10, 32'h1234_5678));
    tbl.push_back(mk(0, 0,1,0,0, 8'h10, 32'h0,          0,0,0, 8'h10, 32'h1234_5678));
    tbl.push_back(mk(0, 0,1,1,0, 8'h10, 32'h0,          0,0,0, 8'h10, 32'h1234_5678));
    tbl.push_back(mk(0, 0,1,0,0, 8'h11, 32'h0,          1,1,0, 8'h11, 32'h1234_5678));
    tbl.push_back(mk(0, 0,0,0,0, 8'h11, 32'h0,          0,0,0, 8'h11, 32'h1234_5678));
    // MIN_WAIT=4 with early ack; a second ack and an addr change must be ignored
    tbl.push_back(mk(1, 1,0,0,0, 8'h00, 32'h0,          0,0,0, 8'h00, 32'h0));
    tbl.push_back(mk(1, 0,1,0,0, 8'h22, 32'h0,          1,1,0, 8'h22, 32'h0));
    tbl.push_back(mk(1, 0,1,0,1, 8'h22, 32'hAAAA_5555,  1,0,0, 8'h22, 32'hAAAA_5555));
    tbl.push_back(mk(1, 0,1,0,1, 8'hEE, 32'h0000_FFFF,  1,0,0, 8'h22, 32'hAAAA_5555));
    tbl.push_back(mk(1, 0,1,0,0, 8'h22, 32'h0,          1,0,0, 8'h22, 32'hAAAA_5555));
    tbl.push_back(mk(1, 0,1,0,0, 8'h22, 32'h0,          0,0,0, 8'h22, 32'hAAAA_5555));
    tbl.push_back(mk(1, 0,0,1,0, 8'h22, 32'h0,          0,0,0, 8'h22, 32'hAAAA_5555));
    // Aborts: rd drop in T_REQ, reset in T_HOLD, then a clean read
    tbl.push_back(mk(0, 1,0,0,0, 8'h00, 32'h0,          0,0,0, 8'h00, 32'h0));
    tbl.push_back(mk(0, 0,1,0,0, 8'h44, 32'h0,          1,1,0, 8'h44, 32'h0));
    tbl.push_back(mk(0, 0,0,0,0, 8'h44, 32'h0,          0,0,0, 8'h44, 32'h0));
    tbl.push_back(mk(0, 0,0,0,1, 8'h44, 32'h1111_1111,  0,0,0, 8'h44, 32'h0));
    tbl.push_back(mk(0, 0,1,0,0, 8'h55, 32'h0,          1,1,0, 8'h55, 32'h0));
    tbl.push_back(mk(0, 0,1,0,1, 8'h55, 32'h0BAD_F00D,  0,0,0, 8'h55, 32'h0BAD_F00D));
    tbl.push_back(mk(0, 1,1,0,0, 8'h55, 32'h0,          0,0,0, 8'h00, 32'h0));
    tbl.push_back(mk(0, 0,1,0,0, 8'h66, 32'h0,          1,1,0, 8'h66, 32'h0));
    tbl.push_back(mk(0, 0,1,0,1, 8'h66, 32'h600D_CAFE,  0,0,0, 8'h66, 32'h600D_CAFE));
    tbl.push_back(mk(0, 0,0,1,0, 8'h66, 32'h0,          0,0,0, 8'h66, 32'h600D_CAFE));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rd, tbl[i].ds, tbl[i].ack, tbl[i].addr, tbl[i].md);
      step;
      chk_dut($sformatf("vec%0d", i), tbl[i].dut, tbl[i].ews, tbl[i].emr,
              tbl[i].eerr, tbl[i].ema, tbl[i].erd);
    end

    // Slow memory: ack on the 20th T_REQ cycle
    drive(1, 0, 0, 0, 8'h00, 32'h0); step;
    drive(0, 1, 0, 0, 8'h77, 32'h0); step;
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("slow_c%0d.ws", c), 32'(ws_w[0]), 32'd1);
      chk($sformatf("slow_c%0d.mem_req", c), 32'(mr_w[0]), 32'd1);
      drive(0, 1, 0, (c == 20), 8'h77, 32'hC0DE_0000 + 32'(c));
      step;
    end
    chk_dut("slow_done", 0, 0, 0, 0, 8'h77, 32'hC0DE_0014);
    drive(0, 0, 1, 0, 8'h00, 32'h0); step;

    // Timeout on TIMEOUT=8 instance, then a late ack
    drive(1, 0, 0, 0, 8'h00, 32'h0); step;
    drive(0, 1, 0, 0, 8'h88, 32'h0); step;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("tmo_c%0d.ws", c), 32'(ws_w[2]), 32'd1);
      drive(0, 1, 0, 0, 8'h88, 32'h0);
      step;
    end
    chk_dut("tmo_done", 2, 0, 0, 1, 8'h88, 32'hDEAD_BEEF);
    drive(0, 1, 0, 1, 8'h88, 32'h1212_1212); step;
    chk_dut("tmo_late_ack", 2, 0, 0, 1, 8'h88, 32'hDEAD_BEEF);
    drive(0, 0, 1, 0, 8'h00, 32'h0); step;

    // Ack on the timeout cycle wins over the error response
    drive(0, 1, 0, 0, 8'h99, 32'h0); step;
    chk("coll_c1.err", 32'(err_w[2]), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("coll_c%0d.ws", c), 32'(ws_w[2]), 32'd1);
      drive(0, 1, 0, (c == 8), 8'h99, 32'h5A5A_5A5A);
      step;
    end
    chk_dut("coll_done", 2, 0, 0, 0, 8'h99, 32'h5A5A_5A5A);
    drive(0, 0, 1, 0, 8'h00, 32'h0); step;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
